mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back formatting for the 5-stage MIPS core.
- Captures MEM-stage results and performs load byte/halfword selection and sign/zero extension.
- Selects the write-back source and drives the register-file write port (pc, we, write index, write data) one cycle later.
- Keeps a retired-instruction counter for the bench.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into pc_w on reset and on flush.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hold all W-stage registers this cycle.
- flush  in  1  load a bubble into W this cycle.
- valid_m  in  1  MEM stage holds a real instruction.
- pc_m  in  32  PC of the MEM-stage instruction.
- we_m  in  1  instruction writes the register file.
- rd_m  in  5  destination register index.
- wb_sel_m  in  2  0=ALU result, 1=load data, 2=pc_m+8 (jal/jalr), 3=reserved (treated as 0).
- ld_type_m  in  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, others treated as lw.
- alu_m  in  32  ALU result / memory address.
- rdata_m  in  32  raw word read from data memory, word-aligned.
- pc_w  out  32  PC presented to the register file.
- we_w  out  1  register-file write enable.
- rd_w  out  5  register-file write index.
- wd_w  out  32  register-file write data.
- valid_w  out  1  W stage holds a real instruction.
- retired  out  CNT_W  count of instructions that have left W.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - pc_w=PC_RESET, we_w=0, rd_w=0, wd_w=0, valid_w=0, retired=0.
  - Effective as soon as reset asserts, not at the next edge.
- Priority at each rising edge: reset > flush > stall > normal capture.
- Normal capture, 1-cycle latency:
  - pc_w<=pc_m, rd_w<=rd_m, valid_w<=valid_m.
  - we_w<=we_m & valid_m.
  - wd_w<=formatted data.
- Formatted data by wb_sel_m:
  - 0 or 3: alu_m.
  - 2: pc_m+8, modulo 2^32.
  - 1: load-extended value (below).
- Load extension, byte offset b=alu_m[1:0]:
  - lw: rdata_m; b ignored, no alignment trap.
  - lh/lhu: halfword rdata_m[31:16] if alu_m[1]=1, else rdata_m[15:0]; alu_m[0] ignored. lh sign-extends, lhu zero-extends.
  - lb/lbu: byte rdata_m[8b+7:8b]. lb sign-extends, lbu zero-extends.
- Flush (highest priority after reset):
  - we_w=0, valid_w=0, rd_w=0, wd_w=0, pc_w=PC_RESET.
  - Flush with stall simultaneously: flush wins.
- Stall: every W register, including retired, holds its value.
- rd_m=0 with we_m=1:
  - Propagates unchanged: we_w=1, rd_w=0, wd_w=formatted data.
  - The register file ignores the write but logs it.
- Retired counter:
  - Increments by 1 on each rising edge where valid_w=1 and neither stall nor flush is asserted. Flush does not count the instruction leaving W.
  - Wraps from all-ones to 0 with no flag.
- Outputs are purely registered; no combinational path from MEM inputs to W outputs.

Test Plan:
- Reset then ALU write: reset pulse; valid_m=1, we_m=1, rd_m=5, wb_sel_m=0, alu_m=32'h1234_5678, pc_m=32'h3000 -> next edge pc_w=3000, we_w=1, rd_w=5, wd_w=12345678, valid_w=1; retired=1 one edge later.
- Load extension: rdata_m=32'h80FF_7F01, wb_sel_m=1.
  - lb b=0 -> 00000001; lb b=1 -> 0000007F; lb b=2 -> FFFFFFFF; lbu b=3 -> 00000080.
  - lh alu_m[1]=1 -> FFFF80FF; lhu alu_m[1]=0 -> 00007F01; lw b=2 -> 80FF7F01.
- Link value: wb_sel_m=2, pc_m=32'hFFFF_FFFC, rd_m=31 -> wd_w=00000004, rd_w=31.
- Stall/flush interaction:
  - Stall held 3 cycles while MEM inputs change -> W outputs and retired frozen.
  - stall=1 and flush=1 together -> we_w=0, valid_w=0, pc_w=PC_RESET, retired unchanged.
- Asynchronous reset mid-stream: assert reset between edges with we_w=1 -> we_w=0 and retired=0 before the next clk edge.
- Counter wrap: with CNT_W=4, retire 17 valid instructions -> retired=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extension and write-back select.
// Drives the register-file write port one cycle after MEM.
module mem_wb_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_m,
  input  logic [31:0]      pc_m,
  input  logic             we_m,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       wb_sel_m,
  input  logic [2:0]       ld_type_m,
  input  logic [31:0]      alu_m,
  input  logic [31:0]      rdata_m,
  output logic [31:0]      pc_w,
  output logic             we_w,
  output logic [4:0]       rd_w,
  output logic [31:0]      wd_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] retired
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] wd_next;

  always_comb begin
    ld_byte = rdata_m[7:0];
    unique case (alu_m[1:0])
      2'd0: ld_byte = rdata_m[7:0];
      2'd1: ld_byte = rdata_m[15:8];
      2'd2: ld_byte = rdata_m[23:16];
      2'd3: ld_byte = rdata_m[31:24];
      default: ld_byte = rdata_m[7:0];
    endcase
  end

  // alu_m[0] is ignored for halfwords; no misalignment trap here
  assign ld_half = alu_m[1] ? rdata_m[31:16] : rdata_m[15:0];

  always_comb begin
    ld_val = rdata_m;
    case (ld_type_m)
      3'd1: ld_val = {{16{ld_half[15]}}, ld_half};
      3'd2: ld_val = {16'h0000, ld_half};
      3'd3: ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd4: ld_val = {24'h000000, ld_byte};
      default: ld_val = rdata_m;
    endcase
  end

  always_comb begin
    wd_next = alu_m;
    case (wb_sel_m)
      2'd1: wd_next = ld_val;
      2'd2: wd_next = pc_m + 32'd8;
      default: wd_next = alu_m;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_w    <= PC_RESET;
      we_w    <= 1'b0;
      rd_w    <= 5'd0;
      wd_w    <= 32'd0;
      valid_w <= 1'b0;
      retired <= '0;
    end else if (flush) begin
      pc_w    <= PC_RESET;
      we_w    <= 1'b0;
      rd_w    <= 5'd0;
      wd_w    <= 32'd0;
      valid_w <= 1'b0;
    end else if (!stall) begin
      pc_w    <= pc_m;
      we_w    <= we_m & valid_m;
      rd_w    <= rd_m;
      wd_w    <= wd_next;
      valid_w <= valid_m;
      if (valid_w)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Second instance uses a 4-bit counter to exercise wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_m = 1'b0;
  logic [31:0] pc_m = '0;
  logic        we_m = 1'b0;
  logic [4:0]  rd_m = '0;
  logic [1:0]  wb_sel_m = '0;
  logic [2:0]  ld_type_m = '0;
  logic [31:0] alu_m = '0;
  logic [31:0] rdata_m = '0;

  logic [31:0] pc_w, pc_w4;
  logic        we_w, we_w4;
  logic [4:0]  rd_w, rd_w4;
  logic [31:0] wd_w, wd_w4;
  logic        valid_w, valid_w4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_ret;
  logic        exp_vw;
  logic [31:0] hold_pc, hold_wd, hold_ret;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_m(valid_m), .pc_m(pc_m), .we_m(we_m), .rd_m(rd_m),
    .wb_sel_m(wb_sel_m), .ld_type_m(ld_type_m), .alu_m(alu_m),
    .rdata_m(rdata_m), .pc_w(pc_w), .we_w(we_w), .rd_w(rd_w),
    .wd_w(wd_w), .valid_w(valid_w), .retired(retired)
  );

  mem_wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_m(valid_m), .pc_m(pc_m), .we_m(we_m), .rd_m(rd_m),
    .wb_sel_m(wb_sel_m), .ld_type_m(ld_type_m), .alu_m(alu_m),
    .rdata_m(rdata_m), .pc_w(pc_w4), .we_w(we_w4), .rd_w(rd_w4),
    .wd_w(wd_w4), .valid_w(valid_w4), .retired(retired4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // unstalled, unflushed edge: counter advances if W held a valid op
  task automatic tick_norm();
    if (exp_vw) exp_ret = exp_ret + 1;
    exp_vw = valid_m;
    tick();
  endtask

  task automatic load(input logic [2:0] lt, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
    ld_type_m = lt;
    alu_m     = a;
    tick_norm();
    chk(tag, wd_w, exp);
  endtask

  initial begin
    exp_ret = 0;
    exp_vw  = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_pc", pc_w, 32'h0000_3000);
    chk("rst_we", {31'd0, we_w}, 32'd0);
    chk("rst_rd", {27'd0, rd_w}, 32'd0);
    chk("rst_wd", wd_w, 32'd0);
    chk("rst_valid", {31'd0, valid_w}, 32'd0);
    chk("rst_ret", retired, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    valid_m = 1'b1; we_m = 1'b1; rd_m = 5'd5; wb_sel_m = 2'd0;
    alu_m = 32'h1234_5678; pc_m = 32'h0000_3000;
    tick_norm();
    chk("alu_pc", pc_w, 32'h0000_3000);
    chk("alu_we", {31'd0, we_w}, 32'd1);
    chk("alu_rd", {27'd0, rd_w}, 32'd5);
    chk("alu_wd", wd_w, 32'h1234_5678);
    chk("alu_valid", {31'd0, valid_w}, 32'd1);
    chk("alu_ret0", retired, 32'd0);

    rd_m = 5'd1; wb_sel_m = 2'd1; rdata_m = 32'h80FF_7F01;
    load(3'd3, 32'h0000_1000, 32'h0000_0001, "lb_b0");
    chk("alu_ret1", retired, 32'd1);
    load(3'd3, 32'h0000_1001, 32'h0000_007F, "lb_b1");
    load(3'd3, 32'h0000_1002, 32'hFFFF_FFFF, "lb_b2");
    load(3'd4, 32'h0000_1003, 32'h0000_0080, "lbu_b3");
    load(3'd4, 32'h0000_1002, 32'h0000_00FF, "lbu_b2");
    load(3'd1, 32'h0000_1002, 32'hFFFF_80FF, "lh_hi");
    load(3'd1, 32'h0000_1003, 32'hFFFF_80FF, "lh_hi_odd");
    load(3'd1, 32'h0000_1000, 32'h0000_7F01, "lh_lo");
    load(3'd2, 32'h0000_1000, 32'h0000_7F01, "lhu_lo");
    load(3'd0, 32'h0000_1002, 32'h80FF_7F01, "lw_b2");
    load(3'd6, 32'h0000_1001, 32'h80FF_7F01, "ld_other");
    chk("ret_loads", retired, 32'd11);

    wb_sel_m = 2'd2; pc_m = 32'hFFFF_FFFC; rd_m = 5'd31;
    tick_norm();
    chk("link_wd", wd_w, 32'h0000_0004);
    chk("link_rd", {27'd0, rd_w}, 32'd31);
    chk("link_pc", pc_w, 32'hFFFF_FFFC);

    wb_sel_m = 2'd3; alu_m = 32'hAABB_CCDD; rd_m = 5'd0;
    tick_norm();
    chk("sel3_wd", wd_w, 32'hAABB_CCDD);
    chk("r0_we", {31'd0, we_w}, 32'd1);
    chk("r0_rd", {27'd0, rd_w}, 32'd0);

    valid_m = 1'b0; rd_m = 5'd9;
    tick_norm();
    chk("inv_we", {31'd0, we_w}, 32'd0);
    chk("inv_valid", {31'd0, valid_w}, 32'd0);
    valid_m = 1'b1; wb_sel_m = 2'd0; alu_m = 32'h0000_0777;
    pc_m = 32'h0000_3040; rd_m = 5'd7;
    tick_norm();
    chk("inv_ret", retired, exp_ret);
    chk("inv_ret_val", retired, 32'd14);

    hold_pc = pc_w; hold_wd = wd_w; hold_ret = retired;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_m = alu_m + 32'h100;
      pc_m  = pc_m + 32'd4;
      tick();
      chk("stall_pc", pc_w, hold_pc);
      chk("stall_wd", wd_w, hold_wd);
      chk("stall_ret", retired, hold_ret);
    end

    flush = 1'b1;
    tick();
    chk("fl_we", {31'd0, we_w}, 32'd0);
    chk("fl_valid", {31'd0, valid_w}, 32'd0);
    chk("fl_pc", pc_w, 32'h0000_3000);
    chk("fl_rd", {27'd0, rd_w}, 32'd0);
    chk("fl_wd", wd_w, 32'd0);
    chk("fl_ret", retired, hold_ret);
    stall = 1'b0; flush = 1'b0;
    exp_vw = 1'b0;

    tick_norm();
    chk("pre_ar_we", {31'd0, we_w}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_we", {31'd0, we_w}, 32'd0);
    chk("ar_ret", retired, 32'd0);
    chk("ar_pc", pc_w, 32'h0000_3000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) tick();
    chk("wrap4", {28'd0, retired4}, 32'd1);
    chk("ret17", retired, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
